status_led_ctrl: RTL and testbench

Sequencer and arbiter for the board's single status LED. Three requesters share the LED: fault blink-codes, identify and heartbeat. The block picks one by fixed priority and times its pattern from a prescaled tick. It replaces the free-running blinker in the top level; the LED pin is driven only from `led`.

---
 rtl/status_led_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_status_led_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_led_ctrl.sv
// status_led_ctrl: arbitrates the board's single status LED between fault
// blink-codes, identify and heartbeat (fixed priority, fault highest) and
// times the chosen pattern from a prescaled tick.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   fault_req   in   fault blink-code requested (level)
//   fault_code  in   pulses per fault code, 0 means no fault
//   ident_req   in   identify pattern requested (level)
//   hb_en       in   heartbeat enabled (level)
//   led         out  LED drive (registered)
//   busy        out  fault sequence in progress (registered)
//   active_src  out  current owner: 0 none, 1 heartbeat, 2 ident, 3 fault
module status_led_ctrl #(
  parameter int unsigned TICK_DIV  = 10,
  parameter int unsigned ON_TICKS  = 1,
  parameter int unsigned OFF_TICKS = 1,
  parameter int unsigned GAP_TICKS = 4,
  parameter int unsigned HB_TICKS  = 2,
  parameter int unsigned CODE_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fault_req,
  input  logic [CODE_W-1:0] fault_code,
  input  logic              ident_req,
  input  logic              hb_en,
  output logic              led,
  output logic              busy,
  output logic [1:0]        active_src
);

  localparam int unsigned DIV_W  = $clog2(TICK_DIV);
  localparam int unsigned MAX_OO = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned MAX_GH = (GAP_TICKS > HB_TICKS) ? GAP_TICKS : HB_TICKS;
  localparam int unsigned MAX_T  = (MAX_OO > MAX_GH) ? MAX_OO : MAX_GH;
  localparam int unsigned CNT_W  = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ON    = 3'd1,
    S_OFF   = 3'd2,
    S_GAP   = 3'd3,
    S_IDENT = 3'd4,
    S_HB    = 3'd5
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div;
  logic              tick;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [CODE_W-1:0] pulses_left, pulses_nxt, pulses_dec;
  logic              led_nxt, busy_nxt;
  logic [1:0]        src_nxt;
  logic              fault_valid;

  assign tick        = (div == DIV_W'(TICK_DIV - 1));
  assign fault_valid = fault_req && (fault_code != '0);
  // Saturating decrement: the pulse count never wraps below zero.
  assign pulses_dec  = (pulses_left != '0) ? (pulses_left - CODE_W'(1)) : '0;

  // Pattern tick prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (tick) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pulses_left <= '0;
      led         <= 1'b0;
      busy        <= 1'b0;
      active_src  <= 2'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pulses_left <= pulses_nxt;
      led         <= led_nxt;
      busy        <= busy_nxt;
      active_src  <= src_nxt;
    end
  end

  // Next-state and next-output logic; everything holds between ticks.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pulses_nxt = pulses_left;
    led_nxt    = led;
    src_nxt    = active_src;

    if (tick) begin
      unique case (state)
        S_IDLE: begin
          if (fault_valid) begin
            pulses_nxt = fault_code;
            led_nxt    = 1'b1;
            src_nxt    = 2'd3;
            cnt_nxt    = '0;
            state_nxt  = S_ON;
          end else if (ident_req) begin
            led_nxt   = 1'b1;
            src_nxt   = 2'd2;
            state_nxt = S_IDENT;
          end else if (hb_en) begin
            led_nxt   = 1'b1;
            src_nxt   = 2'd1;
            cnt_nxt   = '0;
            state_nxt = S_HB;
          end else begin
            led_nxt = 1'b0;
            src_nxt = 2'd0;
          end
        end

        S_ON: begin
          if (cnt == CNT_W'(ON_TICKS - 1)) begin
            cnt_nxt    = '0;
            led_nxt    = 1'b0;
            pulses_nxt = pulses_dec;
            state_nxt  = (pulses_dec != '0) ? S_OFF : S_GAP;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end

        S_OFF: begin
          if (cnt == CNT_W'(OFF_TICKS - 1)) begin
            cnt_nxt   = '0;
            led_nxt   = 1'b1;
            state_nxt = S_ON;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (cnt == CNT_W'(GAP_TICKS - 1)) begin
            cnt_nxt   = '0;
            led_nxt   = 1'b0;
            src_nxt   = 2'd0;
            state_nxt = S_IDLE;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end

        S_IDENT: begin
          if (fault_valid || !ident_req) begin
            led_nxt   = 1'b0;
            state_nxt = S_IDLE;
          end else begin
            led_nxt = ~led;
          end
        end

        S_HB: begin
          if (fault_valid || ident_req || !hb_en) begin
            led_nxt   = 1'b0;
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
          end else if (cnt == CNT_W'(HB_TICKS - 1)) begin
            led_nxt = ~led;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end

        default: begin
          cnt_nxt   = '0;
          led_nxt   = 1'b0;
          src_nxt   = 2'd0;
          state_nxt = S_IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt == S_ON) || (state_nxt == S_OFF) || (state_nxt == S_GAP);
  end

endmodule

// File: tb/tb_status_led_ctrl.sv
// Bench for status_led_ctrl: directed scenarios plus randomized request
// segments, every cycle compared against a pattern-level reference model.
module tb_status_led_ctrl;

  localparam int unsigned TD   = 4;
  localparam int unsigned ONT  = 1;
  localparam int unsigned OFFT = 1;
  localparam int unsigned GAPT = 4;
  localparam int unsigned HBT  = 2;
  localparam int unsigned CW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          fault_req;
  logic [CW-1:0] fault_code;
  logic          ident_req;
  logic          hb_en;
  logic          led;
  logic          busy;
  logic [1:0]    active_src;

  always #5 clk = ~clk;

  status_led_ctrl #(
    .TICK_DIV (TD),
    .ON_TICKS (ONT),
    .OFF_TICKS(OFFT),
    .GAP_TICKS(GAPT),
    .HB_TICKS (HBT),
    .CODE_W   (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fault_req (fault_req),
    .fault_code(fault_code),
    .ident_req (ident_req),
    .hb_en     (hb_en),
    .led       (led),
    .busy      (busy),
    .active_src(active_src)
  );

  int n_chk = 0;
  int n_bad = 0;
  int edge_n;

  // Reference model: a fault code is expanded into a per-tick list of
  // (led, busy) levels; ident/heartbeat levels come from elapsed ticks.
  logic       q_led[$];
  logic       q_busy[$];
  int         mode;     // 0 none, 1 heartbeat, 2 ident
  int         k;        // ticks since the current ident/heartbeat started
  logic       m_led;
  logic       m_busy;
  logic [1:0] m_src;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_led.delete();
    q_busy.delete();
    mode   = 0;
    k      = 0;
    m_led  = 1'b0;
    m_busy = 1'b0;
    m_src  = 2'd0;
  endtask

  task automatic push(input logic l, input logic b);
    q_led.push_back(l);
    q_busy.push_back(b);
  endtask

  task automatic pop_level();
    m_led  = q_led.pop_front();
    m_busy = q_busy.pop_front();
    if (!m_busy) m_src = 2'd0;
  endtask

  task automatic model_tick();
    bit fv;
    int n;
    fv = fault_req && (fault_code != '0);
    if (q_led.size() > 0) begin
      pop_level();
    end else if (mode == 0) begin
      if (fv) begin
        n = int'(fault_code);
        for (int p = 0; p < n; p++) begin
          for (int i = 0; i < int'(ONT); i++) push(1'b1, 1'b1);
          if (p < n - 1) for (int i = 0; i < int'(OFFT); i++) push(1'b0, 1'b1);
          else           for (int i = 0; i < int'(GAPT); i++) push(1'b0, 1'b1);
        end
        push(1'b0, 1'b0);
        m_src = 2'd3;
        pop_level();
      end else if (ident_req) begin
        mode = 2; k = 0; m_led = 1'b1; m_src = 2'd2;
      end else if (hb_en) begin
        mode = 1; k = 0; m_led = 1'b1; m_src = 2'd1;
      end else begin
        m_led = 1'b0; m_src = 2'd0;
      end
    end else if (mode == 1) begin
      if (fv || ident_req || !hb_en) begin
        m_led = 1'b0; mode = 0;
      end else begin
        k++;
        m_led = ((k / int'(HBT)) % 2) == 0;
      end
    end else begin
      if (fv || !ident_req) begin
        m_led = 1'b0; mode = 0;
      end else begin
        k++;
        m_led = (k % 2) == 0;
      end
    end
  endtask

  // One clock: model advances on tick edges, outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    edge_n++;
    if (edge_n % int'(TD) == 0) model_tick();
    #1;
    chk("led", led, m_led);
    chk("busy", busy, m_busy);
    chk("src", active_src, m_src);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic reset_mid();
    reset = 1'b1;
    #1;
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_src", active_src, 0);
    model_reset();
    @(negedge clk);
    reset  = 1'b0;
    edge_n = 0;
  endtask

  initial begin
    int hi;
    int bs;
    int waited;
    int len;

    reset      = 1'b1;
    fault_req  = 1'b0;
    fault_code = '0;
    ident_req  = 1'b0;
    hb_en      = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_led", led, 0);
    chk("init_busy", busy, 0);
    chk("init_src", active_src, 0);
    reset  = 1'b0;
    edge_n = 0;

    // Idle for 200 cycles.
    repeat (200) step();

    // Code 3 held: one 40-cycle period; mid-sequence code change and ident ignored.
    fault_code = 4'd3;
    fault_req  = 1'b1;
    repeat (3) step();
    hi = 0;
    bs = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (led === 1'b1) hi++;
      if (busy === 1'b1) bs++;
      if (i == 8) begin
        fault_code = 4'd5;
        ident_req  = 1'b1;
      end
    end
    chk("period_hi", hi, 12);
    chk("period_busy", bs, 36);
    fault_req = 1'b0;
    repeat (80) step();

    // Heartbeat, then ident takes over, then a zero code has no effect.
    ident_req = 1'b0;
    hb_en     = 1'b1;
    repeat (40) step();
    ident_req = 1'b1;
    repeat (24) step();
    fault_req  = 1'b1;
    fault_code = '0;
    repeat (24) step();

    // All three requests together with code 1.
    fault_code = 4'd1;
    repeat (48) step();

    // Reset in the middle of an ON pulse, then restart from IDLE.
    ident_req  = 1'b0;
    hb_en      = 1'b0;
    fault_code = 4'd2;
    fault_req  = 1'b1;
    waited = 0;
    while (!(m_led && m_busy) && waited < 40) begin
      step();
      waited++;
    end
    chk("wait_on", (m_led && m_busy) ? 1 : 0, 1);
    reset_mid();
    repeat (3) step();
    chk("restart_dark", led, 0);
    step();
    chk("restart_led", led, 1);
    chk("restart_src", active_src, 3);
    repeat (40) step();

    // Randomized request segments.
    for (int s = 0; s < 60; s++) begin
      fault_req  = ($urandom % 3) == 0;
      fault_code = (($urandom % 8) == 0) ? CW'($urandom_range(0, 15))
                                         : CW'($urandom_range(0, 3));
      ident_req  = $urandom % 2;
      hb_en      = $urandom % 2;
      if (($urandom % 15) == 0) reset_mid();
      len = $urandom_range(4, 120);
      for (int c = 0; c < len; c++) begin
        step();
        if (($urandom % 50) == 0) ident_req = ~ident_req;
        if (($urandom % 50) == 0) fault_code = CW'($urandom_range(0, 6));
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
